// File: rtl/lcd_pkg.sv
// Shared types for the HD44780 4-bit write-only controller: FSM states,
// wait classes and the fixed power-on init sequence.
package lcd_pkg;

  typedef enum logic [2:0] {PWRUP, INIT, IDLE, SETUP, EHI, ELO, EXEC} state_t;

  typedef enum logic [1:0] {W_SHORT, W_LONG, W_GAP} wait_t;

  typedef struct packed {
    logic       is_byte;
    logic [7:0] val;
    wait_t      wt;
  } init_item_t;

  localparam logic [2:0] INIT_LAST = 3'd7;

  // Single-nibble entries carry their nibble in val[7:4].
  function automatic init_item_t init_item(input logic [2:0] idx);
    init_item_t it;
    case (idx)
      3'd0:    it = '{1'b0, 8'h30, W_GAP};
      3'd1:    it = '{1'b0, 8'h30, W_SHORT};
      3'd2:    it = '{1'b0, 8'h30, W_SHORT};
      3'd3:    it = '{1'b0, 8'h20, W_SHORT};
      3'd4:    it = '{1'b1, 8'h28, W_SHORT};
      3'd5:    it = '{1'b1, 8'h0C, W_SHORT};
      3'd6:    it = '{1'b1, 8'h01, W_LONG};
      default: it = '{1'b1, 8'h06, W_SHORT};
    endcase
    return it;
  endfunction

  // Clear display and return home need the long execution time.
  function automatic logic is_long_cmd(input logic rs, input logic [7:0] d);
    return !rs && (d == 8'h01 || d == 8'h02 || d == 8'h03);
  endfunction

endpackage

// File: rtl/lcd_nibble_tx.sv
// One HD44780 nibble strobe: SETUP (bus valid, E low), EHI (E high), ELO (E low).
// A start in the last ELO cycle chains the next nibble with no gap.
module lcd_nibble_tx
  import lcd_pkg::*;
#(
  parameter int SETUP_CYC = 2,
  parameter int EHI_CYC   = 8,
  parameter int ELO_CYC   = 27
) (
  input  logic       sys_clk,
  input  logic       rst_n,
  input  logic       i_start,
  input  logic [3:0] i_nib,
  input  logic       i_rs,
  output logic       o_done,
  output logic       o_e,
  output logic       o_rs,
  output logic [3:0] o_db
);

  localparam int MAXC = (SETUP_CYC > EHI_CYC) ?
                        ((SETUP_CYC > ELO_CYC) ? SETUP_CYC : ELO_CYC) :
                        ((EHI_CYC > ELO_CYC) ? EHI_CYC : ELO_CYC);
  localparam int CW = $clog2(MAXC + 2);

  state_t        r_phase;
  logic [CW-1:0] r_cnt;
  logic          r_e;
  logic          r_rs;
  logic [3:0]    r_db;

  assign o_done = (r_phase == ELO) && (r_cnt <= CW'(1));
  assign o_e    = r_e;
  assign o_rs   = r_rs;
  assign o_db   = r_db;

  // A load of 0 still dwells one cycle because every phase exits at count <= 1.
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_phase <= IDLE;
      r_cnt   <= '0;
      r_e     <= 1'b0;
      r_rs    <= 1'b0;
      r_db    <= 4'h0;
    end else if (i_start) begin
      r_phase <= SETUP;
      r_cnt   <= CW'(SETUP_CYC);
      r_e     <= 1'b0;
      r_rs    <= i_rs;
      r_db    <= i_nib;
    end else begin
      case (r_phase)
        SETUP: begin
          if (r_cnt <= CW'(1)) begin
            r_phase <= EHI;
            r_cnt   <= CW'(EHI_CYC);
            r_e     <= 1'b1;
          end else begin
            r_cnt <= r_cnt - CW'(1);
          end
        end
        EHI: begin
          if (r_cnt <= CW'(1)) begin
            r_phase <= ELO;
            r_cnt   <= CW'(ELO_CYC);
            r_e     <= 1'b0;
          end else begin
            r_cnt <= r_cnt - CW'(1);
          end
        end
        ELO: begin
          if (r_cnt <= CW'(1)) r_phase <= IDLE;
          else                 r_cnt   <= r_cnt - CW'(1);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/lcd_ctrl.sv
// HD44780 4-bit write-only controller: power-up wait, fixed init sequence,
// then one byte per request as two nibbles followed by an execution wait.
//
// state | meaning
// PWRUP | post-reset power-up wait
// INIT  | load next init entry and launch its first nibble
// IDLE  | init complete, waiting for a request
// SETUP | nibble strobe running (lcd_nibble_tx walks SETUP/EHI/ELO)
// EXEC  | execution wait after the last nibble of an entry or byte
module lcd_ctrl
  import lcd_pkg::*;
#(
  parameter int SETUP_CYC      = 2,
  parameter int EHI_CYC        = 8,
  parameter int ELO_CYC        = 27,
  parameter int SHORT_WAIT_CYC = 1080,
  parameter int LONG_WAIT_CYC  = 44280,
  parameter int POWERUP_CYC    = 1080000,
  parameter int INIT_GAP_CYC   = 110700
) (
  input  logic       sys_clk,
  input  logic       rst_n,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic       req_rs,
  input  logic [7:0] req_data,
  output logic       init_done,
  output logic       busy,
  output logic       lcd_e,
  output logic       lcd_rw,
  output logic       lcd_rs,
  output logic [3:0] lcd_db
);

  localparam int M1    = (POWERUP_CYC > INIT_GAP_CYC) ? POWERUP_CYC : INIT_GAP_CYC;
  localparam int M2    = (LONG_WAIT_CYC > SHORT_WAIT_CYC) ? LONG_WAIT_CYC : SHORT_WAIT_CYC;
  localparam int MAXW  = (M1 > M2) ? M1 : M2;
  localparam int CNT_W = ($clog2(MAXW + 1) > 21) ? $clog2(MAXW + 1) : 21;

  function automatic logic [CNT_W-1:0] wait_len(input wait_t wt);
    case (wt)
      W_LONG:  return CNT_W'(LONG_WAIT_CYC);
      W_GAP:   return CNT_W'(INIT_GAP_CYC);
      default: return CNT_W'(SHORT_WAIT_CYC);
    endcase
  endfunction

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [2:0]       r_step;
  logic [3:0]       r_lo;
  logic             r_rs;
  logic             r_is_byte;
  logic             r_hi;
  wait_t            r_wt;
  logic             r_init_done;

  init_item_t w_item;
  logic       w_accept;
  logic       w_tx_done;
  logic       w_next_lo;
  logic       w_start;
  logic [3:0] w_nib;
  logic       w_rs;

  assign w_item    = init_item(r_step);
  assign req_ready = (r_state == IDLE) && r_init_done;
  assign w_accept  = req_valid && req_ready;
  assign w_next_lo = (r_state == SETUP) && w_tx_done && r_hi && r_is_byte;
  assign init_done = r_init_done;
  assign busy      = (r_state != IDLE);
  assign lcd_rw    = 1'b0;

  // The first nibble launches in the same cycle the entry is taken, so the
  // strobe's SETUP begins on the cycle after accept.
  always_comb begin
    w_start = 1'b0;
    w_nib   = r_lo;
    w_rs    = r_rs;
    if (w_accept) begin
      w_start = 1'b1;
      w_nib   = req_data[7:4];
      w_rs    = req_rs;
    end else if (r_state == INIT) begin
      w_start = 1'b1;
      w_nib   = w_item.val[7:4];
      w_rs    = 1'b0;
    end else if (w_next_lo) begin
      w_start = 1'b1;
    end
  end

  lcd_nibble_tx #(
    .SETUP_CYC (SETUP_CYC),
    .EHI_CYC   (EHI_CYC),
    .ELO_CYC   (ELO_CYC)
  ) u_tx (
    .sys_clk (sys_clk),
    .rst_n   (rst_n),
    .i_start (w_start),
    .i_nib   (w_nib),
    .i_rs    (w_rs),
    .o_done  (w_tx_done),
    .o_e     (lcd_e),
    .o_rs    (lcd_rs),
    .o_db    (lcd_db)
  );

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= PWRUP;
      r_cnt       <= CNT_W'(POWERUP_CYC);
      r_step      <= 3'd0;
      r_lo        <= 4'h0;
      r_rs        <= 1'b0;
      r_is_byte   <= 1'b0;
      r_hi        <= 1'b0;
      r_wt        <= W_SHORT;
      r_init_done <= 1'b0;
    end else begin
      case (r_state)
        PWRUP: begin
          if (r_cnt <= CNT_W'(1)) begin
            r_state <= INIT;
            r_step  <= 3'd0;
          end else begin
            r_cnt <= r_cnt - CNT_W'(1);
          end
        end
        INIT: begin
          r_lo      <= w_item.val[3:0];
          r_rs      <= 1'b0;
          r_is_byte <= w_item.is_byte;
          r_wt      <= w_item.wt;
          r_hi      <= 1'b1;
          r_state   <= SETUP;
        end
        IDLE: begin
          if (w_accept) begin
            r_lo      <= req_data[3:0];
            r_rs      <= req_rs;
            r_is_byte <= 1'b1;
            r_hi      <= 1'b1;
            r_wt      <= is_long_cmd(req_rs, req_data) ? W_LONG : W_SHORT;
            r_state   <= SETUP;
          end
        end
        SETUP: begin
          if (w_tx_done) begin
            if (w_next_lo) begin
              r_hi <= 1'b0;
            end else begin
              r_state <= EXEC;
              r_cnt   <= wait_len(r_wt);
            end
          end
        end
        EXEC: begin
          if (r_cnt <= CNT_W'(1)) begin
            if (r_init_done) begin
              r_state <= IDLE;
            end else if (r_step == INIT_LAST) begin
              r_init_done <= 1'b1;
              r_state     <= IDLE;
            end else begin
              r_step  <= r_step + 3'd1;
              r_state <= INIT;
            end
          end else begin
            r_cnt <= r_cnt - CNT_W'(1);
          end
        end
        default: r_state <= PWRUP;
      endcase
    end
  end

endmodule

// File: tb/tb_lcd_ctrl.sv
// Randomized self-checking bench for lcd_ctrl with small timing parameters;
// expected nibble stream and latencies come from a queue-based reference model.
module tb_lcd_ctrl;

  localparam int P_PWR   = 20;
  localparam int P_GAP   = 10;
  localparam int P_SHORT = 5;
  localparam int P_LONG  = 15;
  localparam int P_SETUP = 1;
  localparam int P_EHI   = 2;
  localparam int P_ELO   = 3;
  localparam int NIB_CYC = P_SETUP + P_EHI + P_ELO;

  logic       sys_clk   = 1'b0;
  logic       rst_n     = 1'b0;
  logic       req_valid = 1'b0;
  logic       req_rs    = 1'b0;
  logic [7:0] req_data  = 8'h00;
  logic       req_ready;
  logic       init_done;
  logic       busy;
  logic       lcd_e;
  logic       lcd_rw;
  logic       lcd_rs;
  logic [3:0] lcd_db;

  lcd_ctrl #(
    .SETUP_CYC      (P_SETUP),
    .EHI_CYC        (P_EHI),
    .ELO_CYC        (P_ELO),
    .SHORT_WAIT_CYC (P_SHORT),
    .LONG_WAIT_CYC  (P_LONG),
    .POWERUP_CYC    (P_PWR),
    .INIT_GAP_CYC   (P_GAP)
  ) dut (
    .sys_clk   (sys_clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_rs    (req_rs),
    .req_data  (req_data),
    .init_done (init_done),
    .busy      (busy),
    .lcd_e     (lcd_e),
    .lcd_rw    (lcd_rw),
    .lcd_rs    (lcd_rs),
    .lcd_db    (lcd_db)
  );

  always #5 sys_clk = ~sys_clk;

  int n_chk  = 0;
  int n_fail = 0;
  int cyc    = 0;

  // Reference model: every E pulse must match the head of this {rs, db} queue.
  logic [4:0] exp_q[$];

  task automatic chk(input string tag, input int obs, input int exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed %0d (0x%0h) expected %0d (0x%0h) at cycle %0d",
               tag, obs, obs, exp, exp, cyc);
    end
  endtask

  task automatic push_init();
    logic [3:0] nibs [12];
    nibs = '{4'h3, 4'h3, 4'h3, 4'h2, 4'h2, 4'h8, 4'h0, 4'hC, 4'h0, 4'h1, 4'h0, 4'h6};
    for (int i = 0; i < 12; i++) exp_q.push_back({1'b0, nibs[i]});
  endtask

  // Bus monitor, sampled on the falling edge.
  logic       prev_e    = 1'b0;
  logic       prev_done = 1'b0;
  logic [4:0] prev_bus  = 5'h0;
  logic [4:0] rise_val  = 5'h0;
  int         hi_w      = 0;
  int         last_fall = 0;
  int         bad_ready = 0;

  always @(negedge sys_clk) begin
    cyc++;
    if (!rst_n) begin
      prev_e    = 1'b0;
      prev_done = 1'b0;
      hi_w      = 0;
    end else begin
      if (req_ready && !init_done) bad_ready++;
      if (lcd_e && !prev_e) begin
        hi_w     = 1;
        rise_val = {lcd_rs, lcd_db};
        chk("rw_low", int'(lcd_rw), 0);
        chk("setup_hold", int'({lcd_rs, lcd_db}), int'(prev_bus));
        if (exp_q.size() == 0) chk("extra_pulse", exp_q.size(), 1);
        else                   chk("nibble", int'({lcd_rs, lcd_db}), int'(exp_q.pop_front()));
      end else if (lcd_e) begin
        hi_w++;
      end else if (prev_e) begin
        chk("ehi_width", hi_w, P_EHI);
        chk("bus_stable", int'({lcd_rs, lcd_db}), int'(rise_val));
        last_fall = cyc;
      end
      if (init_done && !prev_done) chk("init_done_delay", cyc - last_fall, P_ELO + P_SHORT);
      prev_e    = lcd_e;
      prev_done = init_done;
    end
    prev_bus = {lcd_rs, lcd_db};
  end

  // Called just after a falling edge; returns at a falling edge with req_ready high.
  task automatic send(input logic rs, input logic [7:0] d, input bit keep_valid);
    int n;
    int lat;
    int w;
    req_rs    = rs;
    req_data  = d;
    req_valid = 1'b1;
    n = 0;
    while (!req_ready && n < 2000) begin
      @(negedge sys_clk);
      n++;
    end
    if (!req_ready) begin
      chk("accept_timeout", n, -1);
      req_valid = 1'b0;
      return;
    end
    chk("accept_after_init", int'(init_done), 1);
    @(posedge sys_clk);
    exp_q.push_back({rs, d[7:4]});
    exp_q.push_back({rs, d[3:0]});
    w = (!rs && d >= 8'h01 && d <= 8'h03) ? P_LONG : P_SHORT;
    @(negedge sys_clk);
    chk("ready_drop", int'(req_ready), 0);
    chk("busy_xfer", int'(busy), 1);
    if (!keep_valid) req_valid = 1'b0;
    lat = 1;
    while (!req_ready && lat < 2000) begin
      @(negedge sys_clk);
      lat++;
    end
    chk("latency", lat, 1 + 2 * NIB_CYC + w);
  endtask

  task automatic reset_in_ehi();
    int n;
    req_rs    = 1'b1;
    req_data  = 8'h5A;
    req_valid = 1'b1;
    n = 0;
    while (!req_ready && n < 2000) begin
      @(negedge sys_clk);
      n++;
    end
    @(posedge sys_clk);
    exp_q.push_back({1'b1, 4'h5});
    @(negedge sys_clk);
    req_valid = 1'b0;
    n = 0;
    while (!lcd_e && n < 50) begin
      @(negedge sys_clk);
      n++;
    end
    if (!lcd_e) chk("ehi_timeout", n, -1);
    #2;
    rst_n = 1'b0;
    exp_q.delete();
    push_init();
    #1;
    chk("rst_async_e", int'(lcd_e), 0);
    chk("rst_async_init_done", int'(init_done), 0);
    chk("rst_async_busy", int'(busy), 1);
    chk("rst_async_ready", int'(req_ready), 0);
    repeat (2) @(negedge sys_clk);
    rst_n = 1'b1;
  endtask

  initial begin
    logic       rs;
    logic [7:0] d;
    bit         keep;

    push_init();
    repeat (3) @(negedge sys_clk);
    chk("rst_e", int'(lcd_e), 0);
    chk("rst_rs", int'(lcd_rs), 0);
    chk("rst_db", int'(lcd_db), 0);
    chk("rst_ready", int'(req_ready), 0);
    chk("rst_init_done", int'(init_done), 0);
    chk("rst_busy", int'(busy), 1);
    chk("rst_rw", int'(lcd_rw), 0);
    rst_n = 1'b1;

    // Valid is raised immediately and held through power-up and init.
    send(1'b1, 8'h41, 1'b0);
    send(1'b0, 8'h01, 1'b0);
    send(1'b1, 8'h01, 1'b0);
    send(1'b0, 8'h02, 1'b0);
    send(1'b0, 8'h03, 1'b1);

    for (int i = 0; i < 4; i++) begin
      send(1'($urandom_range(0, 1)), 8'($urandom), i < 3);
    end
    req_valid = 1'b0;
    @(negedge sys_clk);

    for (int i = 0; i < 12; i++) begin
      rs   = 1'($urandom_range(0, 1));
      d    = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(1, 3)) : 8'($urandom);
      keep = 1'($urandom_range(0, 1));
      send(rs, d, keep);
      if (!keep) repeat ($urandom_range(0, 3)) @(negedge sys_clk);
    end
    req_valid = 1'b0;
    @(negedge sys_clk);

    reset_in_ehi();
    send(1'b1, 8'h41, 1'b0);

    repeat (30) @(negedge sys_clk);
    chk("queue_drained", exp_q.size(), 0);
    chk("ready_before_init", bad_ready, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog expired");
  end

endmodule
